// File: rtl/uart_tx_cfg_if.sv
// rtl/uart_tx_cfg_if.sv - write-side handshake bundle for uart_tx_cfg
interface uart_tx_cfg_if #(
  parameter int DATA_W = 9
) ();
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART transmitter with baud divider, TX FIFO and runtime frame format
module uart_tx_cfg #(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_cfg_if.slave     wr,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [3:0]       cfg_data_bits,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  input  logic             cfg_cts_en,
  input  logic             cfg_flush,
  input  logic             cts_n,
  output logic             tx,
  output logic             rts_n,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             irq_done,
  output logic             irq_empty
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam logic [3:0] NB_MIN = 4'd5;
  localparam logic [3:0] NB_MAX = 4'(DATA_W_MAX);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_W_MAX-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  logic [1:0]            cts_sync;
  logic                  cts_ok;

  logic [2:0]            state;
  logic [DIV_W-1:0]      baud_cnt;
  logic [DIV_W-1:0]      div_l;
  logic [3:0]            nbits_l;
  logic [3:0]            bit_idx;
  logic                  par_en_l;
  logic                  par_bit_l;
  logic                  stop2_l;
  logic                  stop_idx;
  logic [DATA_W_MAX-1:0] shreg;
  logic                  tick;
  logic                  last_stop;
  logic                  frame_end;

  logic [3:0]            nbits_cfg;
  logic [DATA_W_MAX-1:0] head_data;
  logic                  head_par_en;
  logic                  head_par_bit;
  logic                  tx_d;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign wr.wready  = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      cts_sync <= 2'b11;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
    end
  end

  assign cts_ok    = !cfg_cts_en || !cts_sync[1];
  assign tick      = (state != S_IDLE) && (baud_cnt == div_l);
  assign last_stop = !stop2_l || stop_idx;
  assign frame_end = (state == S_STOP) && tick && last_stop;

  // A new frame starts either from IDLE or straight out of the last stop bit.
  assign push = wr.wvalid && !fifo_full && !cfg_flush;
  assign pop  = !fifo_empty && cts_ok && !cfg_flush && ((state == S_IDLE) || frame_end);

  always_comb begin
    if (cfg_data_bits < NB_MIN) begin
      nbits_cfg = NB_MIN;
    end else if (cfg_data_bits > NB_MAX) begin
      nbits_cfg = NB_MAX;
    end else begin
      nbits_cfg = cfg_data_bits;
    end
  end

  // Inactive upper bits are cleared so the parity XOR only sees the frame's data.
  always_comb begin
    head_data = mem[rd_ptr];
    for (int i = 0; i < DATA_W_MAX; i++) begin
      if (4'(i) >= nbits_cfg) begin
        head_data[i] = 1'b0;
      end
    end
  end

  assign head_par_en  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
  assign head_par_bit = (^head_data) ^ (cfg_parity == 2'b10);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      div_l     <= '0;
      nbits_l   <= NB_MIN;
      bit_idx   <= '0;
      par_en_l  <= 1'b0;
      par_bit_l <= 1'b0;
      stop2_l   <= 1'b0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
    end else begin
      baud_cnt <= ((state == S_IDLE) || tick) ? '0 : baud_cnt + DIV_W'(1);
      if (tick) begin
        case (state)
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
          S_DATA: begin
            shreg    <= shreg >> 1;
            bit_idx  <= bit_idx + 4'd1;
            stop_idx <= 1'b0;
            if (bit_idx == nbits_l - 4'd1) begin
              state <= par_en_l ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
          S_STOP: begin
            if (last_stop) begin
              state <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      // Frame configuration is captured here and held until the frame ends.
      if (pop) begin
        state     <= S_START;
        shreg     <= head_data;
        div_l     <= cfg_div;
        nbits_l   <= nbits_cfg;
        par_en_l  <= head_par_en;
        par_bit_l <= head_par_bit;
        stop2_l   <= cfg_stop2;
      end
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg[0];
      S_PARITY: tx_d = par_bit_l;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      rts_n     <= 1'b1;
      irq_done  <= 1'b0;
      irq_empty <= 1'b0;
    end else begin
      tx        <= tx_d;
      busy      <= (state != S_IDLE);
      rts_n     <= fifo_empty && (state == S_IDLE);
      irq_done  <= frame_end;
      irq_empty <= pop && !push && (fifo_level == LVL_W'(1));
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter that generalises the fixed 8-bit, parity-always, external-tck transmitter. It has an internal baud divider on the system clock and a parametrised TX FIFO. Data width (5-9 bits), parity mode (none/even/odd) and stop bits (1/2) are runtime-selectable. CTS flow control is optional. It sits between the register/bus front-end (push side) and the UART pad (tx line).

Parameters:
DATA_W_MAX, 9, width of the FIFO entry and write data; the max data bits per frame
FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2
DIV_W, 16, width of the baud divisor
LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level output

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cfg_div  in  DIV_W  baud divisor; each bit lasts cfg_div+1 clk cycles
cfg_data_bits  in  4  data bits per frame, legal 5..9; values <5 behave as 5, values >9 behave as 9
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  in  1  1 = two stop bits, 0 = one
cfg_cts_en  in  1  1 = honour cts_n
cfg_flush  in  1  level; FIFO held empty while high
wdata  in  DATA_W_MAX  write data, LSB-aligned
wvalid  in  1  write request
wready  out  1  = !fifo_full
cts_n  in  1  clear-to-send, active-low; synchronised internally by a 2-flop synchroniser
tx  out  1  serial line, idle high
rts_n  out  1  low while the FIFO is non-empty or a frame is in progress
busy  out  1  high from START through the last STOP bit
fifo_level  out  LVL_W  current entry count
fifo_empty  out  1  level == 0
fifo_full  out  1  level == FIFO_DEPTH
irq_done  out  1  1-cycle pulse at the end of each frame
irq_empty  out  1  1-cycle pulse when the FIFO transitions to empty because of a pop

Behaviour:
- Reset values: tx=1, rts_n=1, busy=0, irq_*=0, fifo_level=0, fifo_empty=1, fifo_full=0, wready=1. State is IDLE, the baud counter is 0, and FIFO pointers are 0.
- Reset mid-frame aborts the frame immediately; tx is 1 on the next cycle.
- FIFO write accepted when wvalid && wready. A write while full is dropped. There is no bypass: push when full is rejected even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: level is unchanged.
- cfg_flush: pointers and level are cleared each cycle while high, and writes are ignored. A frame already in progress completes.
- Baud tick: the counter runs only outside IDLE. It increments each clk and, on reaching cfg_div, reloads 0 and asserts the bit-end tick. cfg_div=0 gives 1 clk per bit.
- Config latching: cfg_div, cfg_data_bits, cfg_parity and cfg_stop2 are latched at frame start. Changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: if FIFO non-empty and (!cfg_cts_en or synced cts_n==0):
  - pop one entry, latch data and config, go to START;
  - this is the same cycle the pop occurs.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - LSB first; the bit counter runs 0..data_bits-1;
  - bits above data_bits-1 are ignored;
  - after the last bit, go to PARITY if parity is enabled, else STOP.
- PARITY: one bit time.
  - Even mode: XOR of the active data bits.
  - Odd mode: the inverted XOR.
- STOP:
  - tx=1 for 1 or 2 bit times;
  - irq_done pulses on the final tick;
  - if the FIFO is non-empty and CTS allows, go directly to START (back-to-back frames, no idle bit);
  - otherwise go to IDLE.
- CTS is checked only at frame start; deassertion mid-frame never truncates a frame.
- tx is registered. Latency: a write accepted at edge N into an empty FIFO with the FSM IDLE and CTS allowing gives tx falling at edge N+2.
- Frame length in clk cycles = (cfg_div+1) × (1 + data_bits + parity_en + 1 + cfg_stop2).

Test Plan:
- cfg_div=3, 8N1, write 0x55 -> tx low at write+2 edges, then bits 1,0,1,0,1,0,1,0, then stop 1. Each bit lasts 4 clks, the frame is 40 clks, irq_done pulses once, busy falls after the frame.
- cfg_div=0, 7E2, write 0x41 -> data 1,0,0,0,0,0,1, parity 0, two stop bits; frame is 11 clks. Switching to odd parity gives parity bit 1.
- 9-bit, no parity, write 0x1FF then 0x000 back-to-back -> second START immediately follows the first STOP with no idle cycle. irq_empty pulses at the second pop.
- Fill FIFO_DEPTH+2 writes with cts_n=1 and cfg_cts_en=1 -> fifo_full=1, wready=0, 2 writes dropped, tx stays 1. Releasing cts_n gives 16 frames in write order.
- Mid-frame: drive cts_n high, change cfg_div and assert cfg_flush -> the current frame completes unchanged and the FIFO empties. Asserting rst mid-frame gives tx=1, busy=0, level=0 on the next cycle.
